// File: rtl/reg_bank.sv
// General-purpose register file: two combinational read ports, one synchronous write port.
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_bank #(
  parameter  int BITS     = 8,
  parameter  int REG_SIZE = 4,
  localparam int REG_BITS = $clog2(REG_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_enable,
  input  logic [REG_BITS-1:0] write_address,
  input  logic [BITS-1:0]     write_data,
  input  logic [REG_BITS-1:0] address_a,
  input  logic [REG_BITS-1:0] address_b,
  output logic [BITS-1:0]     data_a,
  output logic [BITS-1:0]     data_b
);

  logic [BITS-1:0] regs [REG_SIZE];

  // Reset clears every entry and wins over a coincident write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[write_address] <= write_data;
    end
  end

`ifdef REG_BANK_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  // Forwarding is gated by rst so the outputs stay at zero throughout reset.
  assign fwd_a = write_enable && !rst && (address_a == write_address);
  assign fwd_b = write_enable && !rst && (address_b == write_address);

  assign data_a = fwd_a ? write_data : regs[address_a];
  assign data_b = fwd_b ? write_data : regs[address_b];
`else
  assign data_a = regs[address_a];
  assign data_b = regs[address_b];
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: reset, fill/wrap passes, vector table, read-during-write.
module tb_reg_bank;

  logic       clk;
  logic       rst;
  logic       write_enable;
  logic [1:0] write_address;
  logic [7:0] write_data;
  logic [1:0] address_a;
  logic [1:0] address_b;
  logic [7:0] data_a;
  logic [7:0] data_b;

  int vectors;
  int miscompares;
  logic [7:0] model [4];

  typedef struct {
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] aa;
    logic [1:0] ab;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  reg_bank dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .address_a    (address_a),
    .address_b    (address_b),
    .data_a       (data_a),
    .data_b       (data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    write_enable  = 1'b1;
    write_address = a;
    write_data    = d;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    model[a] = d;
  endtask

  initial begin
    logic [7:0] exp_pre;
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    write_enable  = 1'b1;
    write_address = 2'd0;
    write_data    = 8'hEE;
    address_a     = 2'd0;
    address_b     = 2'd1;

    // Reset holds priority over a write presented across clock edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_prio_a0", data_a, 8'h00);
    check("rst_b1", data_b, 8'h00);
    address_a = 2'd2;
    address_b = 2'd3;
    #1;
    check("rst_a2", data_a, 8'h00);
    check("rst_b3", data_b, 8'h00);
    write_enable = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    do_write(2'd0, 8'h12);
    do_write(2'd1, 8'h34);
    do_write(2'd2, 8'h56);
    do_write(2'd3, 8'h78);
    address_a = 2'd3;
    address_b = 2'd0;
    #1;
    check("load_a3", data_a, 8'h78);
    check("load_b0", data_b, 8'h12);

    // Asynchronous reset with no clock edge in the observation window.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_a3", data_a, 8'h00);
    check("async_rst_b0", data_b, 8'h00);
    address_a = 2'd1;
    address_b = 2'd2;
    #1;
    check("async_rst_a1", data_a, 8'h00);
    check("async_rst_b2", data_b, 8'h00);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;

    do_write(2'd2, 8'h5A);
    address_a = 2'd2;
    #1;
    check("post_rst_write", data_a, 8'h5A);

    // Fill passes: addresses wrap 0..3, data increments each full pass.
    for (int d = 0; d < 256; d++) begin
      for (int i = 0; i < 4; i++) begin
        do_write(2'(i), 8'(d));
        address_a = 2'(i);
        address_b = 2'(i - 1);
        #1;
        check("fill_a", data_a, 8'(d));
        check("fill_b", data_b, model[2'(i - 1)]);
        @(posedge clk);
      end
    end
    address_b = 2'd3;
    #1;
    check("final_pass_b3", data_b, 8'hFF);

    vecs[0] = '{1'b1, 2'd1, 8'h11, 2'd1, 2'd0, 8'h11, 8'hFF};
    vecs[1] = '{1'b0, 2'd1, 8'hAA, 2'd1, 2'd1, 8'h11, 8'h11};
    vecs[2] = '{1'b1, 2'd3, 8'h3C, 2'd3, 2'd3, 8'h3C, 8'h3C};
    vecs[3] = '{1'b1, 2'd0, 8'h80, 2'd0, 2'd3, 8'h80, 8'h3C};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 8'hFF, 8'h80};
    vecs[5] = '{1'b1, 2'd2, 8'h01, 2'd2, 2'd1, 8'h01, 8'h11};
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      write_enable  = vecs[v].we;
      write_address = vecs[v].waddr;
      write_data    = vecs[v].wdata;
      address_a     = vecs[v].aa;
      address_b     = vecs[v].ab;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      check($sformatf("vec%0d_a", v), data_a, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), data_b, vecs[v].exp_b);
    end

    // Read-during-write on reg 1.
    do_write(2'd1, 8'h11);
    @(negedge clk);
    write_enable  = 1'b1;
    write_address = 2'd1;
    write_data    = 8'h22;
    address_a     = 2'd1;
    address_b     = 2'd2;
    #1;
`ifdef REG_BANK_BYPASS_EN
    exp_pre = 8'h22;
`else
    exp_pre = 8'h11;
`endif
    check("rdw_before_edge", data_a, exp_pre);
    check("rdw_other_port", data_b, 8'h01);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    check("rdw_after_edge", data_a, 8'h22);

    // Combinational read follows an address change with no clock edge.
    address_a = 2'd3;
    #1;
    check("comb_addr_a", data_a, 8'h3C);
    address_b = 2'd0;
    #1;
    check("comb_addr_b", data_b, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Multi-port general-purpose register file for the core datapath.
- Two independent combinational read ports (A, B) and one synchronous write port.
- Feeds operand values to the ALU and stores results written back from the execute stage.

Parameters:
- BITS, 8, data width of each register in bits.
- REG_SIZE, 4, number of registers; must be a power of two, at least 2.
- REG_BITS, $clog2(REG_SIZE) (2 by default), address width; derived localparam, not user-overridable.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-high reset.
- write_enable  input  1  when 1, write_data is stored at write_address on the next rising clk edge.
- write_address  input  REG_BITS  destination register index.
- write_data  input  BITS  value to store.
- address_a  input  REG_BITS  read port A register index.
- address_b  input  REG_BITS  read port B register index.
- data_a  output  BITS  contents of register address_a.
- data_b  output  BITS  contents of register address_b.

Behaviour:
- Storage: REG_SIZE registers of BITS bits each. All registers are equally writable; register 0 is not hardwired.
- Reset: while rst=1, all registers are cleared to 0 asynchronously, independent of clk.
  - data_a and data_b therefore read 0 during and immediately after reset.
  - Reset has priority over a simultaneous write.
  - Deasserting rst mid-cycle loses no subsequent edge: the first rising edge with rst=0 may write.
- Write: on a rising clk edge with rst=0 and write_enable=1, reg[write_address] <= write_data.
  - Single-cycle latency.
  - Exactly one register is modified per write; all others hold.
  - With write_enable=0, nothing changes regardless of write_address and write_data.
- Read: data_a = reg[address_a] and data_b = reg[address_b], purely combinational.
  - No clock latency; outputs follow address changes within the same cycle.
- Both read ports may address the same register, or the register being written, simultaneously.
  - Both ports return identical values in that case.
- Read-during-write (feature disabled): a read of write_address in the write cycle returns the old value.
  - The new value appears after the rising edge.
- Address width rule: addresses are exactly REG_BITS wide, so every address is in range and no out-of-range case exists.
  - Upstream index arithmetic wraps modulo REG_SIZE; for example, address 0 minus 1 selects register REG_SIZE-1.
- No X propagation: with known addresses, outputs are always defined after reset.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined: write-to-read forwarding is added.
  - When write_enable=1 and address_a==write_address, data_a = write_data combinationally in the same cycle.
  - The same rule applies to port B.
  - Forwarding is inactive while rst=1, so outputs read 0.
- Undefined: no forwarding; read-during-write returns the stored old value as described above.

Test Plan:
- Reset: assert rst asynchronously (no clk edge) after registers are loaded -> data_a = data_b = 0x00 for every address. Deassert; a write of 0x5A to reg 2 on the next edge -> data_a = 0x5A at address_a=2.
- Sequential fill: write_data=0x00 to regs 0..3 in turn, one write per two clocks. Each time, read back with address_a = the just-written index and address_b = index-1 modulo 4 -> data_a = 0x00 and data_b = the prior register's value.
- Wrap and data increment: after address 3, write_address wraps to 0 and write_data increments by 1 per full pass. Repeat until write_data=0xFF -> every read matches the last value written to that index, including the 0xFF pass ending at address_b=3.
- Write disable: write_enable=0 with write_address=1, write_data=0xAA -> reg 1 unchanged; data_a at address 1 equals the prior value.
- Dual-port same address: address_a = address_b = 3 after writing 0x3C -> data_a = data_b = 0x3C.
- Read-during-write: reg 1 holds 0x11; write 0x22 to reg 1 while address_a=1.
  - Without REG_BANK_BYPASS_EN: data_a = 0x11 before the edge and 0x22 after it.
  - With REG_BANK_BYPASS_EN: data_a = 0x22 before the edge.
